// File: rtl/treeval_param_pkg.sv
// Shared constants, FSM encoding and width helpers for the tree evaluator.
// No logic here, so no latency or backpressure.
package treeval_pkg;

    localparam int DEF_MAX_NODES = 64;
    localparam int DEF_W_ADDR    = 10;
    localparam int DEF_W_N_DATA  = 12;
    localparam int DEF_W_C_DATA  = 10;
    localparam int DEF_W_REWARD  = 12;
    localparam int DEF_W_ACTION  = 3;
    localparam int DEF_W_WEIGHT  = 8;

    localparam logic [2:0] ACT_PLAY    = 3'b001;
    localparam logic [2:0] ACT_NO_PLAY = 3'b000;

    localparam logic MODE_EXP = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_SWEEP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Accumulator headroom: a full-scale weighted sum over every node cannot overflow.
    function automatic int acc_width(input int w_reward, input int w_weight, input int max_nodes);
        return w_reward + w_weight + $clog2(max_nodes);
    endfunction

endpackage

// File: rtl/treeval_param_if.sv
// Configuration/request strobes in, evaluation result out.
// Plain wires; the evaluator never stalls writes, it aborts and restarts instead.
interface treeval_param_if
    import treeval_pkg::*;
#(
    parameter int W_ADDR   = DEF_W_ADDR,
    parameter int W_N_DATA = DEF_W_N_DATA,
    parameter int W_C_DATA = DEF_W_C_DATA,
    parameter int W_REWARD = DEF_W_REWARD,
    parameter int W_ACTION = DEF_W_ACTION
);
    logic                       mem_par;
    logic                       mem_rew;
    logic                       mem_act;
    logic                       mem_weight;
    logic [W_ADDR-1:0]          mem_addr;
    logic [W_N_DATA-1:0]        mem_data;
    logic                       conf_nodes;
    logic [W_C_DATA-1:0]        conf_data;
    logic                       conf_mode;
    logic                       start;
    logic                       busy;
    logic                       done;
    logic                       exp_change;
    logic signed [W_REWARD-1:0] exp;
    logic [W_ACTION-1:0]        act;
    logic                       err;

    modport master (
        output mem_par, mem_rew, mem_act, mem_weight, mem_addr, mem_data,
               conf_nodes, conf_data, conf_mode, start,
        input  busy, done, exp_change, exp, act, err
    );

    modport slave (
        input  mem_par, mem_rew, mem_act, mem_weight, mem_addr, mem_data,
               conf_nodes, conf_data, conf_mode, start,
        output busy, done, exp_change, exp, act, err
    );

endinterface

// File: rtl/treeval_param_mac.sv
// Weighted accumulate (acc + (w*val)>>>FRAC, floor) and saturation to reward width.
// Purely combinational, zero latency, no backpressure.
module treeval_param_mac
    import treeval_pkg::*;
#(
    parameter int W_ACC    = acc_width(DEF_W_REWARD, DEF_W_WEIGHT, DEF_MAX_NODES),
    parameter int W_WEIGHT = DEF_W_WEIGHT,
    parameter int W_REWARD = DEF_W_REWARD
)(
    input  logic [W_WEIGHT-1:0]        weight,
    input  logic signed [W_ACC-1:0]    val,
    input  logic signed [W_ACC-1:0]    acc_in,
    output logic signed [W_ACC-1:0]    acc_out,
    input  logic signed [W_ACC-1:0]    sat_in,
    output logic signed [W_REWARD-1:0] sat_out
);
    localparam int FRAC   = W_WEIGHT - 1;
    localparam int W_PROD = W_ACC + W_WEIGHT + 1;

    localparam logic signed [W_ACC-1:0] SAT_HI = {{(W_ACC-W_REWARD+1){1'b0}}, {(W_REWARD-1){1'b1}}};
    localparam logic signed [W_ACC-1:0] SAT_LO = ~SAT_HI;

    logic signed [W_PROD-1:0] prod;
    logic signed [W_PROD-1:0] scaled;

    always_comb begin
        // Weight is unsigned; a zero MSB keeps it positive in the signed multiply.
        prod    = W_PROD'($signed({1'b0, weight})) * W_PROD'(val);
        scaled  = prod >>> FRAC;
        acc_out = acc_in + W_ACC'(scaled);
    end

    always_comb begin
        if (sat_in > SAT_HI) begin
            sat_out = SAT_HI[W_REWARD-1:0];
        end else if (sat_in < SAT_LO) begin
            sat_out = SAT_LO[W_REWARD-1:0];
        end else begin
            sat_out = sat_in[W_REWARD-1:0];
        end
    end

endmodule

// File: rtl/treeval_param.sv
// Evaluates a reward tree bottom-up (expectation or max) into root value and best action.
// Latency N (init) + N-1 (sweep) + 1 cycles; any accepted write aborts and reruns the pass.
module treeval_param
    import treeval_pkg::*;
#(
    parameter int MAX_NODES = DEF_MAX_NODES,
    parameter int W_ADDR    = DEF_W_ADDR,
    parameter int W_N_DATA  = DEF_W_N_DATA,
    parameter int W_C_DATA  = DEF_W_C_DATA,
    parameter int W_REWARD  = DEF_W_REWARD,
    parameter int W_ACTION  = DEF_W_ACTION,
    parameter int W_WEIGHT  = DEF_W_WEIGHT
)(
    input  logic            clk,
    input  logic            rst,
    treeval_param_if.slave  bus
);
    localparam int W_IDX = $clog2(MAX_NODES);
    localparam int W_CNT = W_IDX + 1;
    localparam int W_ACC = acc_width(W_REWARD, W_WEIGHT, MAX_NODES);

    logic [W_IDX-1:0]           parent [MAX_NODES];
    logic signed [W_REWARD-1:0] reward [MAX_NODES];
    logic [W_ACTION-1:0]        action [MAX_NODES];
    logic [W_WEIGHT-1:0]        weight [MAX_NODES];
    logic [MAX_NODES-1:0]       has_child;
    logic [W_CNT-1:0]           n_nodes;
    logic                       err_q;

    logic signed [W_ACC-1:0]    acc [MAX_NODES];
    logic [MAX_NODES-1:0]       seen;

    state_t                     state;
    logic [W_CNT-1:0]           idx;
    logic                       dirty;
    logic                       mode_q;
    logic [W_IDX-1:0]           best;
    logic signed [W_ACC-1:0]    best_val;
    logic                       best_vld;
    logic                       busy_q;
    logic                       done_q;
    logic                       exp_change_q;
    logic signed [W_REWARD-1:0] exp_q;
    logic [W_ACTION-1:0]        act_q;

    logic wr_conf, wr_par, wr_rew, wr_act, wr_wgt, wr_err, wr_ok, addr_ok;
    logic [W_IDX-1:0] a_i, d_i;

    assign a_i = bus.mem_addr[W_IDX-1:0];
    assign d_i = bus.mem_data[W_IDX-1:0];

    // Only the highest-priority strobe is decoded; lower ones are dropped that cycle.
    always_comb begin
        wr_conf = 1'b0;
        wr_par  = 1'b0;
        wr_rew  = 1'b0;
        wr_act  = 1'b0;
        wr_wgt  = 1'b0;
        wr_err  = 1'b0;
        addr_ok = bus.mem_addr < W_ADDR'(n_nodes);
        if (bus.conf_nodes) begin
            wr_conf = 1'b1;
        end else if (bus.mem_par) begin
            if (addr_ok && bus.mem_data < W_N_DATA'(bus.mem_addr)) wr_par = 1'b1;
            else                                                   wr_err = 1'b1;
        end else if (bus.mem_rew) begin
            if (addr_ok) wr_rew = 1'b1;
            else         wr_err = 1'b1;
        end else if (bus.mem_act) begin
            if (addr_ok) wr_act = 1'b1;
            else         wr_err = 1'b1;
        end else if (bus.mem_weight) begin
            if (addr_ok) wr_wgt = 1'b1;
            else         wr_err = 1'b1;
        end
    end

    assign wr_ok = wr_conf | wr_par | wr_rew | wr_act | wr_wgt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MAX_NODES; i++) begin
                parent[i] <= '0;
                reward[i] <= '0;
                action[i] <= '0;
                weight[i] <= '0;
            end
            has_child <= '0;
            n_nodes   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (wr_err) err_q <= 1'b1;
            if (wr_conf) begin
                n_nodes   <= (bus.conf_data > W_C_DATA'(MAX_NODES)) ? W_CNT'(MAX_NODES)
                                                                     : W_CNT'(bus.conf_data);
                has_child <= '0;
            end else if (wr_par) begin
                parent[a_i]    <= d_i;
                has_child[d_i] <= 1'b1;
            end else if (wr_rew) begin
                reward[a_i] <= bus.mem_data[W_REWARD-1:0];
            end else if (wr_act) begin
                action[a_i] <= bus.mem_data[W_ACTION-1:0];
            end else if (wr_wgt) begin
                weight[a_i] <= bus.mem_data[W_WEIGHT-1:0];
            end
        end
    end

    logic [W_IDX-1:0]           cur;
    logic [W_IDX-1:0]           par;
    logic signed [W_ACC-1:0]    val;
    logic signed [W_ACC-1:0]    mac_sum;
    logic signed [W_REWARD-1:0] sat;

    // Children always carry higher indices, so acc[cur] is final when cur is visited.
    assign cur = idx[W_IDX-1:0];
    assign par = parent[cur];
    assign val = has_child[cur] ? acc[cur] : W_ACC'(reward[cur]);

    treeval_param_mac #(
        .W_ACC    (W_ACC),
        .W_WEIGHT (W_WEIGHT),
        .W_REWARD (W_REWARD)
    ) u_mac (
        .weight  (weight[cur]),
        .val     (val),
        .acc_in  (acc[par]),
        .acc_out (mac_sum),
        .sat_in  (acc[0]),
        .sat_out (sat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            dirty        <= 1'b0;
            mode_q       <= MODE_EXP;
            best         <= '0;
            best_val     <= '0;
            best_vld     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            exp_change_q <= 1'b0;
            exp_q        <= '0;
            act_q        <= '0;
            seen         <= '0;
            for (int i = 0; i < MAX_NODES; i++) acc[i] <= '0;
        end else begin
            done_q       <= 1'b0;
            exp_change_q <= 1'b0;
            if (wr_ok) dirty <= 1'b1;

            if (wr_ok && state != S_IDLE) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // A write landing on this edge is already visible to the new pass.
                        if (bus.start || dirty) begin
                            mode_q   <= bus.conf_mode;
                            dirty    <= 1'b0;
                            idx      <= '0;
                            best_vld <= 1'b0;
                            busy_q   <= 1'b1;
                            state    <= S_INIT;
                        end
                    end
                    S_INIT: begin
                        acc[cur]  <= '0;
                        seen[cur] <= 1'b0;
                        if (idx + 1'b1 >= n_nodes) begin
                            if (n_nodes < W_CNT'(2)) begin
                                state <= S_DONE;
                            end else begin
                                idx   <= n_nodes - 1'b1;
                                state <= S_SWEEP;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_SWEEP: begin
                        if (mode_q == MODE_MAX) begin
                            if (!seen[par] || val > acc[par]) acc[par] <= val;
                            seen[par] <= 1'b1;
                        end else begin
                            acc[par] <= mac_sum;
                        end
                        if (par == '0 && (!best_vld || val >= best_val)) begin
                            best     <= cur;
                            best_val <= val;
                            best_vld <= 1'b1;
                        end
                        if (idx == W_CNT'(1)) state <= S_DONE;
                        else                  idx   <= idx - 1'b1;
                    end
                    S_DONE: begin
                        exp_q        <= sat;
                        act_q        <= best_vld ? action[best] : W_ACTION'(ACT_NO_PLAY);
                        done_q       <= 1'b1;
                        exp_change_q <= (sat != exp_q);
                        busy_q       <= 1'b0;
                        state        <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.exp_change = exp_change_q;
    assign bus.exp        = exp_q;
    assign bus.act        = act_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_treeval_param.sv
// Directed bench for treeval_param: expectation/max evaluation, errors, abort, saturation, reset.
module tb_treeval_param;
    localparam int K_CONF = 0;
    localparam int K_PAR  = 1;
    localparam int K_REW  = 2;
    localparam int K_ACT  = 3;
    localparam int K_WGT  = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   failed = 0;
    int   done_cnt = 0;
    int   chg_cnt = 0;

    always #5 clk = ~clk;

    treeval_param_if tvif ();

    treeval_param dut (
        .clk (clk),
        .rst (rst),
        .bus (tvif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (tvif.done)       done_cnt++;
        if (tvif.exp_change) chg_cnt++;
    endtask

    task automatic wr(input int kind, input int addr, input int data);
        tvif.mem_addr  = 10'(addr);
        tvif.mem_data  = 12'(data);
        tvif.conf_data = 10'(data);
        case (kind)
            K_CONF:  tvif.conf_nodes = 1'b1;
            K_PAR:   tvif.mem_par    = 1'b1;
            K_REW:   tvif.mem_rew    = 1'b1;
            K_ACT:   tvif.mem_act    = 1'b1;
            default: tvif.mem_weight = 1'b1;
        endcase
        tick();
        tvif.conf_nodes = 1'b0;
        tvif.mem_par    = 1'b0;
        tvif.mem_rew    = 1'b0;
        tvif.mem_act    = 1'b0;
        tvif.mem_weight = 1'b0;
    endtask

    task automatic pulse_start(input logic mode);
        tvif.conf_mode = mode;
        tvif.start     = 1'b1;
        tick();
        tvif.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen_done = 1'b0;
        for (int n = 0; n < 200 && !seen_done; n++) begin
            tick();
            if (tvif.done) seen_done = 1'b1;
        end
        tests++;
        if (!seen_done) begin
            failed++;
            $display("FAIL %s: done got 0 within 200 cycles, expected 1", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        tests++; if (tvif.busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", tvif.busy); end
        tests++; if (tvif.done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b expected 0", tvif.done); end
        tests++; if (tvif.exp !== 12'sd0) begin failed++; $display("FAIL reset_exp: got %0d expected 0", tvif.exp); end
        tests++; if (tvif.act !== 3'd0) begin failed++; $display("FAIL reset_act: got %0d expected 0", tvif.act); end
        tests++; if (tvif.err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b expected 0", tvif.err); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_expectation();
        done_cnt = 0;
        chg_cnt  = 0;
        tvif.conf_mode = 1'b0;
        wr(K_CONF, 0, 7);
        wr(K_PAR, 1, 0); wr(K_PAR, 2, 0); wr(K_PAR, 3, 0);
        wr(K_PAR, 4, 1); wr(K_PAR, 5, 1); wr(K_PAR, 6, 1);
        wr(K_REW, 2, -10); wr(K_REW, 3, 0); wr(K_REW, 4, 100);
        wr(K_REW, 5, -50); wr(K_REW, 6, 10);
        wr(K_ACT, 1, 1); wr(K_ACT, 2, 1); wr(K_ACT, 3, 0);
        wr(K_WGT, 1, 64); wr(K_WGT, 2, 32); wr(K_WGT, 3, 32);
        wr(K_WGT, 4, 64); wr(K_WGT, 5, 32); wr(K_WGT, 6, 32);
        wait_done("exp_mode_done");
        for (int i = 0; i < 5; i++) tick();
        tests++; if (tvif.exp !== 12'sd16) begin failed++; $display("FAIL exp_mode_exp: got %0d expected 16", tvif.exp); end
        tests++; if (tvif.act !== 3'd1) begin failed++; $display("FAIL exp_mode_act: got %0d expected 1", tvif.act); end
        tests++; if (done_cnt !== 1) begin failed++; $display("FAIL exp_mode_done_count: got %0d expected 1", done_cnt); end
        tests++; if (chg_cnt !== 1) begin failed++; $display("FAIL exp_mode_change_count: got %0d expected 1", chg_cnt); end
    endtask

    task automatic test_err();
        done_cnt = 0;
        chg_cnt  = 0;
        wr(K_PAR, 3, 5);
        wr(K_REW, 9, 55);
        for (int i = 0; i < 20; i++) tick();
        tests++; if (tvif.err !== 1'b1) begin failed++; $display("FAIL err_flag: got %b expected 1", tvif.err); end
        tests++; if (done_cnt !== 0) begin failed++; $display("FAIL err_no_eval: got %0d done pulses expected 0", done_cnt); end
        pulse_start(1'b0);
        wait_done("err_done");
        tests++; if (tvif.exp !== 12'sd16) begin failed++; $display("FAIL err_exp: got %0d expected 16", tvif.exp); end
        tests++; if (tvif.act !== 3'd1) begin failed++; $display("FAIL err_act: got %0d expected 1", tvif.act); end
        tests++; if (chg_cnt !== 0) begin failed++; $display("FAIL err_change: got %0d expected 0", chg_cnt); end
    endtask

    task automatic test_max();
        done_cnt = 0;
        chg_cnt  = 0;
        pulse_start(1'b1);
        tick(); tick();
        tests++; if (tvif.busy !== 1'b1) begin failed++; $display("FAIL max_busy: got %b expected 1", tvif.busy); end
        pulse_start(1'b1);
        wait_done("max_done");
        for (int i = 0; i < 4; i++) tick();
        tests++; if (tvif.exp !== 12'sd100) begin failed++; $display("FAIL max_exp: got %0d expected 100", tvif.exp); end
        tests++; if (tvif.act !== 3'd1) begin failed++; $display("FAIL max_act: got %0d expected 1", tvif.act); end
        tests++; if (done_cnt !== 1) begin failed++; $display("FAIL max_done_count: got %0d expected 1", done_cnt); end
        tests++; if (chg_cnt !== 1) begin failed++; $display("FAIL max_change: got %0d expected 1", chg_cnt); end
        done_cnt = 0;
        chg_cnt  = 0;
        pulse_start(1'b1);
        wait_done("max_repeat_done");
        tick();
        tests++; if (done_cnt !== 1) begin failed++; $display("FAIL max_repeat_done_count: got %0d expected 1", done_cnt); end
        tests++; if (chg_cnt !== 0) begin failed++; $display("FAIL max_repeat_change: got %0d expected 0", chg_cnt); end
        tests++; if (tvif.exp !== 12'sd100) begin failed++; $display("FAIL max_repeat_exp: got %0d expected 100", tvif.exp); end
    endtask

    task automatic test_abort();
        done_cnt = 0;
        chg_cnt  = 0;
        pulse_start(1'b0);
        // 7 INIT cycles then the sweep; 9 more edges lands inside the sweep.
        for (int i = 0; i < 9; i++) tick();
        tests++; if (tvif.busy !== 1'b1) begin failed++; $display("FAIL abort_busy: got %b expected 1", tvif.busy); end
        wr(K_REW, 4, -100);
        wait_done("abort_done");
        for (int i = 0; i < 5; i++) tick();
        tests++; if (done_cnt !== 1) begin failed++; $display("FAIL abort_done_count: got %0d expected 1", done_cnt); end
        tests++; if (tvif.exp !== -12'sd34) begin failed++; $display("FAIL abort_exp: got %0d expected -34", tvif.exp); end
        tests++; if (tvif.act !== 3'd0) begin failed++; $display("FAIL abort_act: got %0d expected 0", tvif.act); end
        tests++; if (chg_cnt !== 1) begin failed++; $display("FAIL abort_change: got %0d expected 1", chg_cnt); end
    endtask

    task automatic test_saturate();
        done_cnt = 0;
        tvif.conf_mode = 1'b0;
        wr(K_REW, 4, 2047); wr(K_REW, 5, 2047); wr(K_REW, 6, 2047);
        for (int n = 1; n < 7; n++) wr(K_WGT, n, 128);
        wait_done("sat_done");
        for (int i = 0; i < 4; i++) tick();
        tests++; if (tvif.exp !== 12'sd2047) begin failed++; $display("FAIL sat_exp: got %0d expected 2047", tvif.exp); end
        tests++; if (tvif.act !== 3'd1) begin failed++; $display("FAIL sat_act: got %0d expected 1", tvif.act); end
        tests++; if (done_cnt !== 1) begin failed++; $display("FAIL sat_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_mid_reset();
        int cyc;
        pulse_start(1'b0);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b0;
        tick();
        tests++; if (tvif.busy !== 1'b0) begin failed++; $display("FAIL mrst_busy: got %b expected 0", tvif.busy); end
        tests++; if (tvif.exp !== 12'sd0) begin failed++; $display("FAIL mrst_exp: got %0d expected 0", tvif.exp); end
        tests++; if (tvif.act !== 3'd0) begin failed++; $display("FAIL mrst_act: got %0d expected 0", tvif.act); end
        tests++; if (tvif.err !== 1'b0) begin failed++; $display("FAIL mrst_err: got %b expected 0", tvif.err); end
        tests++; if (tvif.done !== 1'b0) begin failed++; $display("FAIL mrst_done: got %b expected 0", tvif.done); end
        rst = 1'b1;
        wr(K_CONF, 0, 1);
        wait_done("n1_auto_done");
        tick(); tick();
        pulse_start(1'b0);
        tests++; if (tvif.busy !== 1'b1) begin failed++; $display("FAIL n1_busy: got %b expected 1", tvif.busy); end
        cyc = 0;
        while (!tvif.done && cyc < 20) begin
            tick();
            cyc++;
        end
        tests++; if (cyc !== 2) begin failed++; $display("FAIL n1_latency: got %0d cycles expected 2", cyc); end
        tests++; if (tvif.exp !== 12'sd0) begin failed++; $display("FAIL n1_exp: got %0d expected 0", tvif.exp); end
        tests++; if (tvif.act !== 3'd0) begin failed++; $display("FAIL n1_act: got %0d expected 0", tvif.act); end
    endtask

    initial begin
        rst             = 1'b0;
        tvif.mem_par    = 1'b0;
        tvif.mem_rew    = 1'b0;
        tvif.mem_act    = 1'b0;
        tvif.mem_weight = 1'b0;
        tvif.mem_addr   = '0;
        tvif.mem_data   = '0;
        tvif.conf_nodes = 1'b0;
        tvif.conf_data  = '0;
        tvif.conf_mode  = 1'b0;
        tvif.start      = 1'b0;

        test_reset();
        test_expectation();
        test_err();
        test_max();
        test_abort();
        test_saturate();
        test_mid_reset();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/treeval_param.md
TREEVAL_PARAM -- requirements
Module: treeval_param

Interface
REQ-001 SHALL have parameters: MAX_NODES 64 (node storage depth); W_ADDR 10; W_N_DATA 12; W_C_DATA 10; W_REWARD 12 (signed reward/exp width); W_ACTION 3; W_WEIGHT 8 (unsigned weight, FRAC=W_WEIGHT-1, 1.0=2^FRAC).
REQ-002 SHALL have one clock; reset is synchronous and active-low; ports: clk in 1 rising-edge clock; rst in 1 synchronous active-low reset.
REQ-003 SHALL have inputs: mem_par/mem_rew/mem_act/mem_weight 1 each (write strobes); mem_addr W_ADDR (node index); mem_data W_N_DATA (write data, LSB-aligned); conf_nodes 1; conf_data W_C_DATA (node count); conf_mode 1 (0=expectation, 1=max); start 1 (eval request).
REQ-004 SHALL have outputs: busy 1; done 1 (one-cycle pulse); exp_change 1 (one-cycle pulse); exp W_REWARD signed; act W_ACTION; err 1 (sticky).

Function
REQ-005 SHALL store per node: parent, signed reward, action, weight, has_child flag; N = min(conf_data, MAX_NODES) on conf_nodes, which also clears all has_child flags and sets dirty.
REQ-006 SHALL ignore writes with mem_addr >= N, or parent writes with mem_data >= mem_addr, setting err; accepted parent write sets has_child[mem_data].
REQ-007 SHALL set dirty on any accepted write; strobes have priority order conf_nodes > mem_par > mem_rew > mem_act > mem_weight if asserted together (only highest performed).
REQ-008 SHALL use FSM IDLE -> INIT -> SWEEP -> DONE -> IDLE; IDLE leaves when start or dirty, sampling conf_mode and clearing dirty.
REQ-009 INIT SHALL take N cycles clearing acc[i] and seen[i]; SWEEP SHALL take N-1 cycles visiting i = N-1 down to 1; DONE 1 cycle; busy=1 in INIT/SWEEP/DONE.
REQ-010 In SWEEP, val_i = has_child[i] ? acc[i] : reward[i]; expectation mode: acc[parent] += (weight_i * val_i) >>> FRAC (arithmetic, floor); max mode: acc[parent] = seen ? max(acc, val_i) : val_i, seen set.
REQ-011 acc SHALL be W_REWARD+W_WEIGHT+log2(MAX_NODES) bits signed, no internal overflow.
REQ-012 For parent==0 visits, SHALL track best root child by val_i, replacing on >= (ties go to lower index).
REQ-013 In DONE: exp <= acc[0] saturated to W_REWARD signed range; act <= action[best] (0 if root has no child); done=1; exp_change=1 iff new exp != previous exp.
REQ-014 N < 2: SHALL skip SWEEP (INIT then DONE), exp=0, act=0.
REQ-015 Accepted write while busy SHALL abort: return to IDLE without updating exp/act/done, dirty set, re-evaluation starts next cycle.
REQ-016 start while busy SHALL be ignored.

Reset
REQ-017 rst=0 at a clock edge SHALL force: state IDLE, N=0, dirty=0, busy=0, done=0, exp_change=0, exp=0, act=0, err=0; all node fields, has_child, acc cleared; mid-evaluation reset discards the pass.

Structure
REQ-018 Shared package treeval_pkg SHALL hold ACT_PLAY=3'b001, ACT_NO_PLAY=3'b000, FSM state encoding, and default width constants.
REQ-019 Weighted multiply/shift/saturate SHALL be one sub-module treeval_param_mac; node storage stays in the top.

Verification
REQ-020 Tree parents 1,2,3->0, 4,5,6->1; rewards n2=-10, n3=0, n4=100, n5=-50, n6=10; actions n1=1, n2=1, n3=0; weights n1=64, n2=32, n3=32, n4=64, n5=32, n6=32; conf_mode 0 -> exp=16, act=1, done and exp_change pulse once.
REQ-021 Same tree, conf_mode 1, start -> exp=100, act=1, exp_change=1; repeat start with no change -> done pulse, exp_change=0.
REQ-022 Rewards n4=n5=n6=2047, all weights 128 -> exp=2047 (saturated), no wraparound.
REQ-023 Write n4 reward mid-SWEEP -> no done for aborted pass; exactly one done after restart with updated exp.
REQ-024 Parent write addr 3 data 5, and write to addr 9 with N=7 -> err=1, tree unchanged, exp identical to REQ-020.
REQ-025 rst=0 during SWEEP -> next cycle busy=0, exp=0, act=0, err=0; conf_data=1 then start -> done after 2 cycles, exp=0.
